// File: rtl/hx711_pkg.sv
// Shared types and constants for the HX711 serial-side emulator.
package hx711_pkg;

    typedef enum logic [2:0] {
        CONV  = 3'd0,
        READY = 3'd1,
        SHIFT = 3'd2,
        GAIN  = 3'd3,
        PDOWN = 3'd4
    } hx_state_e;

    localparam logic [1:0] GAIN_A128 = 2'd0;
    localparam logic [1:0] GAIN_B32  = 2'd1;
    localparam logic [1:0] GAIN_A64  = 2'd2;

    localparam logic [4:0] PULSES_DATA = 5'd24;
    localparam logic [4:0] PULSES_A128 = 5'd25;
    localparam logic [4:0] PULSES_B32  = 5'd26;
    localparam logic [4:0] PULSES_A64  = 5'd27;

    function automatic logic [1:0] gain_code(input logic [4:0] pulses);
        logic [1:0] code;
        case (pulses)
            PULSES_B32: code = GAIN_B32;
            PULSES_A64: code = GAIN_A64;
            default:    code = GAIN_A128;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/hx711_sck_sync.sv
// Two-flop synchronizer for PD_SCK with rising/falling edge pulses.
module hx711_sck_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck_async,
    output logic sck_sync,
    output logic sck_rise,
    output logic sck_fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= sck_async;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sck_sync = sync_r;
    assign sck_rise = sync_r & ~prev_r;
    assign sck_fall = ~sync_r & prev_r;

endmodule

// File: rtl/hx711_emulator.sv
// HX711 serial-side emulator: DOUT/PD_SCK protocol, gain selection by pulse count.
// Optional power-down on long PD_SCK high is enabled by defining HX711_EMU_PD_EN.
module hx711_emulator
    import hx711_pkg::*;
#(
    parameter int CONV_CYCLES = 500,
    parameter int DOUT_DLY    = 5,
    parameter int GAP_CYCLES  = 1000,
    parameter int PD_CYCLES   = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PD_SCK,
    output logic        DOUT,
    input  logic [23:0] sample_in,
    input  logic        sample_we,
    output logic        sample_taken,
    output logic [1:0]  gain_sel,
    output logic        busy,
    output logic        powered_down
);

    localparam int CONV_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int DLY_W  = $clog2(DOUT_DLY + 1);

    logic sck_s, rise_s, fall_s;

    hx711_sck_sync u_sck_sync (
        .clk       (clk),
        .rst       (rst),
        .sck_async (PD_SCK),
        .sck_sync  (sck_s),
        .sck_rise  (rise_s),
        .sck_fall  (fall_s)
    );

    hx_state_e          state_r, state_nx_s;
    logic [CONV_W-1:0]  conv_cnt_r, conv_cnt_nx_s;
    logic [GAP_W-1:0]   gap_r, gap_nx_s;
    logic [DLY_W-1:0]   dly_cnt_r, dly_cnt_nx_s;
    logic               dly_val_r, dly_val_nx_s;
    logic [4:0]         pulse_r, pulse_nx_s, pulse_inc_s;
    logic [23:0]        pending_r, pending_nx_s;
    logic [23:0]        shreg_r, shreg_nx_s;
    logic               dout_r, dout_nx_s;
    logic [1:0]         gain_r, gain_nx_s;
    logic               taken_r, taken_nx_s;
    logic               busy_r;
    logic               gap_done_s;

`ifdef HX711_EMU_PD_EN
    localparam int PD_W = (PD_CYCLES > 2) ? $clog2(PD_CYCLES) : 1;
    logic [PD_W-1:0] hi_cnt_r, hi_cnt_nx_s;
    logic            pd_hit_s;
    logic            powered_down_r;

    // PD_SCK-high duration counter, saturating at the power-down threshold
    always_comb begin
        hi_cnt_nx_s = hi_cnt_r;
        if (!sck_s) begin
            hi_cnt_nx_s = '0;
        end else if (hi_cnt_r != PD_W'(PD_CYCLES - 1)) begin
            hi_cnt_nx_s = hi_cnt_r + PD_W'(1);
        end else begin
            hi_cnt_nx_s = hi_cnt_r;
        end
        pd_hit_s = sck_s & (hi_cnt_r == PD_W'(PD_CYCLES - 1));
    end

    // power-down counter and status register
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt_r       <= '0;
            powered_down_r <= 1'b0;
        end else begin
            hi_cnt_r       <= hi_cnt_nx_s;
            powered_down_r <= (state_nx_s == PDOWN);
        end
    end

    assign powered_down = powered_down_r;
`else
    assign powered_down = 1'b0;
`endif

    // next-state and datapath logic
    always_comb begin
        state_nx_s    = state_r;
        conv_cnt_nx_s = conv_cnt_r;
        pulse_nx_s    = pulse_r;
        dly_cnt_nx_s  = dly_cnt_r;
        dly_val_nx_s  = dly_val_r;
        dout_nx_s     = dout_r;
        gain_nx_s     = gain_r;
        shreg_nx_s    = shreg_r;
        taken_nx_s    = 1'b0;
        pulse_inc_s   = pulse_r + 5'd1;

        if (sample_we) begin
            pending_nx_s = sample_in;
        end else begin
            pending_nx_s = pending_r;
        end

        // any time spent high restarts the idle-low timer
        if (sck_s) begin
            gap_nx_s = '0;
        end else if (gap_r != GAP_W'(GAP_CYCLES - 1)) begin
            gap_nx_s = gap_r + GAP_W'(1);
        end else begin
            gap_nx_s = gap_r;
        end
        gap_done_s = ~sck_s & (gap_r == GAP_W'(GAP_CYCLES - 1));

        // DOUT trails the detected PD_SCK edge by DOUT_DLY cycles
        if (dly_cnt_r != '0) begin
            dly_cnt_nx_s = dly_cnt_r - DLY_W'(1);
            if (dly_cnt_r == DLY_W'(1)) begin
                dout_nx_s = dly_val_r;
            end else begin
                dout_nx_s = dout_r;
            end
        end else begin
            dly_cnt_nx_s = '0;
        end

        case (state_r)
            CONV: begin
                dout_nx_s    = 1'b1;
                dly_cnt_nx_s = '0;
                if (conv_cnt_r == CONV_W'(CONV_CYCLES - 1)) begin
                    conv_cnt_nx_s = '0;
                    shreg_nx_s    = pending_r;
                    taken_nx_s    = 1'b1;
                    dout_nx_s     = 1'b0;
                    state_nx_s    = READY;
                end else begin
                    conv_cnt_nx_s = conv_cnt_r + CONV_W'(1);
                end
            end
            READY: begin
                dout_nx_s = 1'b0;
                if (rise_s) begin
                    pulse_nx_s   = 5'd1;
                    dly_cnt_nx_s = DLY_W'(DOUT_DLY);
                    dly_val_nx_s = shreg_r[23];
                    state_nx_s   = SHIFT;
                end else begin
                    pulse_nx_s = 5'd0;
                end
            end
            SHIFT: begin
                if (rise_s) begin
                    pulse_nx_s   = pulse_inc_s;
                    dly_cnt_nx_s = DLY_W'(DOUT_DLY);
                    if (pulse_inc_s == PULSES_A128) begin
                        dly_val_nx_s = 1'b1;
                        state_nx_s   = GAIN;
                    end else begin
                        dly_val_nx_s = shreg_r[PULSES_DATA - pulse_inc_s];
                    end
                end else if (gap_done_s) begin
                    // aborted read: gain selection is left untouched
                    dout_nx_s     = 1'b1;
                    dly_cnt_nx_s  = '0;
                    conv_cnt_nx_s = '0;
                    state_nx_s    = CONV;
                end else begin
                    pulse_nx_s = pulse_r;
                end
            end
            GAIN: begin
                if (rise_s) begin
                    if (pulse_r == PULSES_A64) begin
                        pulse_nx_s = PULSES_A64;
                    end else begin
                        pulse_nx_s = pulse_inc_s;
                    end
                end else if ((fall_s && (pulse_r == PULSES_A64)) || gap_done_s) begin
                    gain_nx_s     = gain_code(pulse_r);
                    dout_nx_s     = 1'b1;
                    dly_cnt_nx_s  = '0;
                    conv_cnt_nx_s = '0;
                    state_nx_s    = CONV;
                end else begin
                    pulse_nx_s = pulse_r;
                end
            end
            PDOWN: begin
                dout_nx_s    = 1'b1;
                dly_cnt_nx_s = '0;
                if (!sck_s) begin
                    gain_nx_s     = GAIN_A128;
                    conv_cnt_nx_s = '0;
                    state_nx_s    = CONV;
                end else begin
                    state_nx_s = PDOWN;
                end
            end
            default: begin
                dout_nx_s     = 1'b1;
                dly_cnt_nx_s  = '0;
                conv_cnt_nx_s = '0;
                state_nx_s    = CONV;
            end
        endcase

`ifdef HX711_EMU_PD_EN
        // a long high pulse wins over every other transition this cycle
        if (pd_hit_s) begin
            state_nx_s    = PDOWN;
            dout_nx_s     = 1'b1;
            dly_cnt_nx_s  = '0;
            conv_cnt_nx_s = '0;
            pulse_nx_s    = pulse_r;
            gain_nx_s     = gain_r;
            shreg_nx_s    = shreg_r;
            taken_nx_s    = 1'b0;
        end else begin
        end
`endif
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= CONV;
            conv_cnt_r <= '0;
            gap_r      <= '0;
            dly_cnt_r  <= '0;
            dly_val_r  <= 1'b1;
            pulse_r    <= 5'd0;
            pending_r  <= 24'd0;
            shreg_r    <= 24'd0;
            dout_r     <= 1'b1;
            gain_r     <= GAIN_A128;
            taken_r    <= 1'b0;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            conv_cnt_r <= conv_cnt_nx_s;
            gap_r      <= gap_nx_s;
            dly_cnt_r  <= dly_cnt_nx_s;
            dly_val_r  <= dly_val_nx_s;
            pulse_r    <= pulse_nx_s;
            pending_r  <= pending_nx_s;
            shreg_r    <= shreg_nx_s;
            dout_r     <= dout_nx_s;
            gain_r     <= gain_nx_s;
            taken_r    <= taken_nx_s;
            busy_r     <= (state_nx_s == CONV);
        end
    end

    assign DOUT         = dout_r;
    assign gain_sel     = gain_r;
    assign sample_taken = taken_r;
    assign busy         = busy_r;

endmodule

// File: doc/hx711_emulator.md
# hx711_emulator

Synthesizable model of the HX711 ADC's serial side. It drives DOUT and responds to PD_SCK exactly as the chip does, so the team's HX711 reader can be tested in simulation and on a second FPGA without a load cell. The block sits on the sensor side of the PD_SCK/DOUT pair. A local test source loads 24-bit samples into it, and it reports the gain/channel selected by the reader's trailing pulse count.

## Interface
- `CONV_CYCLES`, default 500: clk cycles of "conversion" (DOUT high) before a sample is presented.
- `DOUT_DLY`, default 5: clk cycles from a detected PD_SCK rising edge to the DOUT update (models T2 ≈ 0.1 µs at 50 MHz).
- `GAP_CYCLES`, default 1000: PD_SCK-low idle time that ends a read burst.
- `PD_CYCLES`, default 3000: PD_SCK-high time that triggers power-down (60 µs at 50 MHz).
- `clk` input, 1 bit: system clock (50 MHz).
- `rst` input, 1 bit: synchronous, active-high reset.
- `PD_SCK` input, 1 bit: serial clock from the reader; asynchronous.
- `DOUT` output, 1 bit: serial data and ready flag, driven from a register.
- `sample_in` input, 24 bits: next sample value, two's complement.
- `sample_we` input, 1 bit: loads `sample_in` into the pending register.
- `sample_taken` output, 1 bit: one-cycle pulse when the pending sample moves into the shift register.
- `gain_sel` output, 2 bits: selected mode. 0 = A/128 (25 pulses), 1 = B/32 (26 pulses), 2 = A/64 (27 pulses).
- `busy` output, 1 bit: high while in CONV.
- `powered_down` output, 1 bit: high while in PDOWN.

## Operation
- PD_SCK passes through a 2-flop synchronizer followed by a rise/fall edge detector. All behaviour below uses the synchronized signal.
- States:
  - CONV: DOUT=1, counter runs to CONV_CYCLES-1. Then the pending sample is copied to the 24-bit shift register, `sample_taken` pulses, and the state goes to READY.
  - READY: DOUT=0; waits for a rising edge, then goes to SHIFT with pulse count 1.
  - SHIFT: on rising edge k (1..24), DOUT = shreg[24-k] after DOUT_DLY cycles (MSB first). On rising edge 25, DOUT=1 after DOUT_DLY and the state goes to GAIN.
  - GAIN: counts further rising edges, saturating at 27. The burst ends on the falling edge of pulse 27, or when PD_SCK stays low for GAP_CYCLES. At the end, `gain_sel` takes the code for the count (25/26/27 → 0/1/2) and the state goes to CONV.
  - PDOWN: DOUT=1, `powered_down`=1. When PD_SCK goes low, the state goes to CONV with `gain_sel` forced to 0 (chip power-up default).
- Aborted read: in SHIFT, if PD_SCK stays low for GAP_CYCLES with fewer than 25 pulses, DOUT goes to 1, `gain_sel` is kept, and the state goes to CONV.
- A rising edge in CONV is ignored; DOUT stays 1.
- `sample_we` is honoured in any state. If `sample_we` coincides with the copy into the shift register, the old pending value is copied and the new value stays pending.
- The pending register is not cleared by a read, so the same value repeats until it is reloaded.

## Timing
- Reset values: DOUT=1, `gain_sel`=0, `busy`=1, `powered_down`=0, `sample_taken`=0, pending=0, shreg=0, state CONV with counter 0.
- `rst` asserted mid-shift aborts the read immediately; DOUT is 1 on the cycle after reset is sampled.
- PD_SCK edge to detection: 2–3 clk cycles. Edge to DOUT change: detection + DOUT_DLY cycles.
- The reader must keep PD_SCK high/low ≥ DOUT_DLY+3 cycles each. Faster pulses are undefined.
- First READY is reached CONV_CYCLES cycles after reset release.

## Configuration
- `HX711_EMU_PD_EN` defined: a PD_SCK-high counter runs in every state. When it reaches PD_CYCLES, the state goes to PDOWN. This has priority over every other transition in the same cycle.
- `HX711_EMU_PD_EN` undefined: there is no counter and no PDOWN state, and `powered_down` is tied to 0. A long high pulse is treated as one ordinary pulse.

## Structure
- `hx711_pkg`: state enum (CONV, READY, SHIFT, GAIN, PDOWN), gain code constants, and pulse-count constants 24/25/26/27.
- Sub-module `hx711_sck_sync`: 2-flop synchronizer with rise/fall pulse outputs. Everything else lives in a single FSM module.

## Test plan
- Reset, load 24'hB2A37A, then 25 PD_SCK pulses (2.1 µs high/low) -> DOUT goes low after 500 cycles; bits read back = 1011_0010_1010_0011_0111_1010; DOUT=1 after pulse 25; `gain_sel`=0.
- Load 24'h6869B3, 26 pulses -> read 0110_1000_0110_1001_1011_0011; `gain_sel`=1. Repeat with 27 pulses -> `gain_sel`=2.
- Abort after 10 pulses, then hold PD_SCK low for 1000 cycles -> DOUT=1, `busy`=1, `gain_sel` unchanged, next READY presents the pending sample.
- With `HX711_EMU_PD_EN`: hold PD_SCK high for 3000 cycles while `gain_sel`=2 -> `powered_down`=1. Release -> CONV with `gain_sel`=0.
- Assert `rst` at pulse 12 -> DOUT=1 the next cycle, all outputs at reset values, READY 500 cycles after release.
- `sample_we` with 24'h0467D1 on the same cycle as `sample_taken` -> current read carries the old value, next read carries 24'h0467D1.
